reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: IdValid  input  1  decode stage holds a valid instruction.
REQ-004 SHALL have ports: IdRs, IdRt  input  5 each  decode source register numbers.
REQ-005 SHALL have ports: IdUseRs, IdUseRt  input  1 each  the matching source is actually read.
REQ-006 SHALL have ports: IdRd  input  5  decode destination register; IdWb  input  1  decode instruction writes IdRd.
REQ-007 SHALL have port: ExRdMask  input  32  one-hot (or zero) destination mask of the Ex-stage instruction, from the register-usage decoder.
REQ-008 SHALL have port: ExIsLoad  input  1  Ex-stage instruction is a load.
REQ-009 SHALL have port: WbRdMask  input  32  one-hot (or zero) destination mask of the Wb-stage instruction.
REQ-010 SHALL have port: Stall  output  1  hold decode and fetch this cycle.
REQ-011 SHALL have port: IdIssue  output  1  decode instruction advances this cycle.
REQ-012 SHALL have ports: FwdRs, FwdRt  output  2 each  operand source: 00 register file, 01 Ex result, 10 Wb result.
REQ-013 SHALL have port: StallCnt  output  8  saturating total stall-cycle count.
REQ-014 SHALL have port: Watchdog  output  1  sticky flag for a stall lasting too long.

Function
REQ-015 SHALL hold register Pending[31:0]; bit r=1 means an issued instruction will write r and has not reached Wb.
REQ-016 SHALL compute haz(r) = (r!=0) & ((ExRdMask[r] & ExIsLoad) | (Pending[r] & ~ExRdMask[r] & ~WbRdMask[r])), i.e. load-use, or writer in Mem stage with no forward path.
REQ-017 SHALL drive Stall = IdValid & ((IdUseRs & haz(IdRs)) | (IdUseRt & haz(IdRt))), combinational, same cycle.
REQ-018 SHALL drive IdIssue = IdValid & ~Stall.
REQ-019 SHALL drive FwdRs (and FwdRt) = 00 if reg is 0 or not used; 01 if ExRdMask[reg] & ~ExIsLoad; else 10 if WbRdMask[reg]; else 00. Ex takes priority over Wb.
REQ-020 SHALL, at each edge, compute Pending_next = (Pending & ~WbRdMask) | set, where set = one-hot(IdRd) when IdIssue & IdWb & IdRd!=0.
REQ-021 SHALL let set win over clear when WbRdMask and set hit the same bit in one cycle.
REQ-022 SHALL keep Pending[0] = 0 at all times.
REQ-023 SHALL implement FSM RUN/STALL: RUN->STALL at the edge when Stall=1; STALL->RUN at the edge when Stall=0; otherwise hold state.
REQ-024 SHALL keep a 4-bit consecutive-stall counter: increment each Stall=1 cycle, saturate at 15, clear on any Stall=0 cycle.
REQ-025 SHALL set Watchdog at the edge where Stall=1 and the consecutive counter already equals 15; Watchdog stays 1 until reset.
REQ-026 SHALL increment StallCnt by 1 on each Stall=1 cycle, saturating at 255 (no wrap).
REQ-027 SHALL treat a non-one-hot nonzero mask input as a violation; behaviour is undefined and is not verified.

Reset
REQ-028 SHALL, on a clock edge with rst_n=0, set Pending=0, FSM=RUN, consecutive counter=0, StallCnt=0 and Watchdog=0, overriding all other updates, including mid-stall.
REQ-029 SHALL keep Stall, IdIssue and Fwd* combinational during reset; with Pending=0 they depend only on the mask inputs.

Verification
REQ-030 Load-use: Ex load to r5 (ExRdMask=1<<5, ExIsLoad=1), ID uses Rs=5 -> Stall=1, IdIssue=0; next cycle load in Wb (WbRdMask=1<<5) -> Stall=0, FwdRs=10.
REQ-031 ALU forward: ExRdMask=1<<8, ExIsLoad=0, ID Rt=8 used -> Stall=0, FwdRt=01; both masks hit r8 -> FwdRt=01.
REQ-032 Mem-stage hazard: issue write to r3, then masks zero for r3 while Pending[3]=1, ID reads r3 -> Stall=1 until WbRdMask=1<<3, then Pending[3]=0 next cycle.
REQ-033 Same-cycle set/clear: WbRdMask=1<<7 and issue with IdRd=7, IdWb=1 -> Pending[7]=1 after edge. IdRd=0 -> Pending unchanged.
REQ-034 Watchdog/saturation: hold Stall=1 for 16 cycles -> Watchdog=1 on 16th edge; hold 300 cycles -> StallCnt=255; rst_n=0 one edge -> all cleared.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Purpose : register scoreboard for a 5-stage pipe; detects load-use and Mem-stage
//           hazards, picks operand forwarding paths, counts stall cycles.
// Latency : Stall/IdIssue/FwdRs/FwdRt are combinational; Pending and counters update at the edge.
// Backpressure: Stall holds decode and fetch; the decode instruction issues only when Stall=0.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   IdValid               decode holds a valid instruction
//   IdRs/IdRt, IdUseRs/Rt decode source registers and whether each is read
//   IdRd, IdWb            decode destination register and write enable
//   ExRdMask, ExIsLoad    one-hot destination of the Ex instruction, and load flag
//   WbRdMask              one-hot destination of the Wb instruction
//   Stall, IdIssue        hold decode / decode advances
//   FwdRs, FwdRt          operand source: 00 regfile, 01 Ex result, 10 Wb result
//   StallCnt              saturating total stall-cycle count
//   Watchdog              sticky: a single stall lasted longer than 15 cycles
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IdValid,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUseRs,
  input  logic        IdUseRt,
  input  logic [4:0]  IdRd,
  input  logic        IdWb,
  input  logic [31:0] ExRdMask,
  input  logic        ExIsLoad,
  input  logic [31:0] WbRdMask,
  output logic        Stall,
  output logic        IdIssue,
  output logic [1:0]  FwdRs,
  output logic [1:0]  FwdRt,
  output logic [7:0]  StallCnt,
  output logic        Watchdog
);

  typedef enum logic {
    stRun   = 1'b0,
    stStall = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pending;
  logic [3:0]  consecCnt;

  logic [31:0] hazVec;
  logic [31:0] exFwdVec;
  logic [31:0] setVec;
  logic [31:0] pendingNext;

  // Operand source select: Ex (non-load) result wins over Wb result.
  function automatic logic [1:0] fwdSel(input logic [4:0]  r,
                                        input logic        used,
                                        input logic [31:0] exV,
                                        input logic [31:0] wbV);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (r != 5'd0)) begin
      if (exV[r]) begin
        sel = 2'b01;
      end else if (wbV[r]) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  always_comb begin
    // A register is hazardous if a load in Ex will write it (data not ready yet),
    // or an issued writer sits in Mem: pending but visible in neither Ex nor Wb,
    // where no forward path exists.
    hazVec    = (ExRdMask & {32{ExIsLoad}}) | (pending & ~ExRdMask & ~WbRdMask);
    hazVec[0] = 1'b0;

    exFwdVec  = ExRdMask & {32{~ExIsLoad}};

    Stall   = IdValid & ((IdUseRs & hazVec[IdRs]) | (IdUseRt & hazVec[IdRt]));
    IdIssue = IdValid & ~Stall;

    FwdRs = fwdSel(IdRs, IdUseRs, exFwdVec, WbRdMask);
    FwdRt = fwdSel(IdRt, IdUseRt, exFwdVec, WbRdMask);

    setVec = '0;
    if (IdIssue && IdWb && (IdRd != 5'd0)) begin
      setVec[IdRd] = 1'b1;
    end

    // Set is OR'd in after the clear, so a new writer issuing in the same cycle
    // an older writer to the same register retires keeps the bit pending.
    pendingNext    = (pending & ~WbRdMask) | setVec;
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      state     <= stRun;
      consecCnt <= 4'd0;
      StallCnt  <= 8'd0;
      Watchdog  <= 1'b0;
    end else begin
      pending <= pendingNext;

      if (state == stRun) begin
        if (Stall) begin
          state <= stStall;
        end
      end else begin
        if (!Stall) begin
          state <= stRun;
        end
      end

      if (Stall) begin
        if (consecCnt != 4'd15) begin
          consecCnt <= consecCnt + 4'd1;
        end
        // Counter already saturated means this is at least the 16th stall in a row.
        if (consecCnt == 4'd15) begin
          Watchdog <= 1'b1;
        end
        if (StallCnt != 8'hFF) begin
          StallCnt <= StallCnt + 8'd1;
        end
      end else begin
        consecCnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose : self-checking bench for reg_scoreboard (reference model plus directed vectors).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled later in the cycle.
// Backpressure: not applicable; the bench only observes Stall/IdIssue.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        IdValid;
  logic [4:0]  IdRs;
  logic [4:0]  IdRt;
  logic        IdUseRs;
  logic        IdUseRt;
  logic [4:0]  IdRd;
  logic        IdWb;
  logic [31:0] ExRdMask;
  logic        ExIsLoad;
  logic [31:0] WbRdMask;
  logic        Stall;
  logic        IdIssue;
  logic [1:0]  FwdRs;
  logic [1:0]  FwdRt;
  logic [7:0]  StallCnt;
  logic        Watchdog;

  int nChk  = 0;
  int nPass = 0;
  bit chkEn = 1'b0;

  // Reference model state: which registers have an issued writer that has not
  // retired, length of the current stall run, total stalls, sticky watchdog.
  bit pend[32];
  int mConsec;
  int mTotal;
  bit mWd;

  reg_scoreboard dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IdValid  (IdValid),
    .IdRs     (IdRs),
    .IdRt     (IdRt),
    .IdUseRs  (IdUseRs),
    .IdUseRt  (IdUseRt),
    .IdRd     (IdRd),
    .IdWb     (IdWb),
    .ExRdMask (ExRdMask),
    .ExIsLoad (ExIsLoad),
    .WbRdMask (WbRdMask),
    .Stall    (Stall),
    .IdIssue  (IdIssue),
    .FwdRs    (FwdRs),
    .FwdRt    (FwdRt),
    .StallCnt (StallCnt),
    .Watchdog (Watchdog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nChk++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Can register r be read this cycle? Reason by where its newest writer is.
  function automatic bit mHaz(input int r);
    if (r == 0) return 1'b0;
    if (ExRdMask[r]) return ExIsLoad;  // writer in Ex: ALU result forwards, load data not ready
    if (WbRdMask[r]) return 1'b0;      // writer in Wb: forwarded
    return pend[r];                    // writer still in flight elsewhere (Mem): must wait
  endfunction

  function automatic bit mStall();
    return IdValid && ((IdUseRs && mHaz(int'(IdRs))) || (IdUseRt && mHaz(int'(IdRt))));
  endfunction

  function automatic logic [1:0] mFwd(input int r, input bit u);
    if (!u || r == 0) return 2'd0;
    if (ExRdMask[r] && !ExIsLoad) return 2'd1;
    if (WbRdMask[r]) return 2'd2;
    return 2'd0;
  endfunction

  // Model update at each edge (inputs are stable here: the bench drives them later).
  always @(posedge clk) begin
    bit s;
    s = mStall();
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
      mConsec = 0;
      mTotal  = 0;
      mWd     = 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (WbRdMask[r]) pend[r] = 1'b0;
      end
      if (IdValid && !s && IdWb && IdRd != 5'd0) pend[IdRd] = 1'b1;
      if (s) begin
        if (mConsec == 15) mWd = 1'b1;
        else mConsec = mConsec + 1;
        if (mTotal < 255) mTotal = mTotal + 1;
      end else begin
        mConsec = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      chk("Stall",    {7'd0, Stall},    {7'd0, mStall()});
      chk("IdIssue",  {7'd0, IdIssue},  {7'd0, IdValid && !mStall()});
      chk("FwdRs",    {6'd0, FwdRs},    {6'd0, mFwd(int'(IdRs), IdUseRs)});
      chk("FwdRt",    {6'd0, FwdRt},    {6'd0, mFwd(int'(IdRt), IdUseRt)});
      chk("StallCnt", StallCnt,         mTotal[7:0]);
      chk("Watchdog", {7'd0, Watchdog}, {7'd0, mWd});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IdValid  = 1'b0;
    IdRs     = 5'd0;
    IdRt     = 5'd0;
    IdUseRs  = 1'b0;
    IdUseRt  = 1'b0;
    IdRd     = 5'd0;
    IdWb     = 1'b0;
    ExRdMask = 32'd0;
    ExIsLoad = 1'b0;
    WbRdMask = 32'd0;
  endtask

  task automatic setStall9();
    idle();
    IdValid  = 1'b1;
    IdRs     = 5'd9;
    IdUseRs  = 1'b1;
    ExRdMask = 32'd1 << 9;
    ExIsLoad = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    mConsec = 0;
    mTotal  = 0;
    mWd     = 1'b0;
    rst_n   = 1'b0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
    chkEn = 1'b1;
    #1;
    chk("rst_StallCnt", StallCnt, 8'd0);
    chk("rst_Watchdog", {7'd0, Watchdog}, 8'd0);
    chk("rst_Stall", {7'd0, Stall}, 8'd0);
    cyc();

    // Load-use on r5, then the load reaches Wb and forwards.
    IdValid = 1'b1; IdRs = 5'd5; IdUseRs = 1'b1;
    ExRdMask = 32'd1 << 5; ExIsLoad = 1'b1;
    #1;
    chk("lu_Stall", {7'd0, Stall}, 8'd1);
    chk("lu_IdIssue", {7'd0, IdIssue}, 8'd0);
    cyc();
    ExRdMask = 32'd0; ExIsLoad = 1'b0; WbRdMask = 32'd1 << 5;
    #1;
    chk("lu_wb_Stall", {7'd0, Stall}, 8'd0);
    chk("lu_wb_FwdRs", {6'd0, FwdRs}, 8'd2);
    chk("lu_wb_IdIssue", {7'd0, IdIssue}, 8'd1);
    chk("lu_StallCnt", StallCnt, 8'd1);
    cyc();

    // ALU forward on r8 from Ex; Ex beats Wb; Wb alone gives 10.
    idle();
    IdValid = 1'b1; IdRt = 5'd8; IdUseRt = 1'b1; ExRdMask = 32'd1 << 8;
    #1;
    chk("alu_Stall", {7'd0, Stall}, 8'd0);
    chk("alu_FwdRt", {6'd0, FwdRt}, 8'd1);
    WbRdMask = 32'd1 << 8;
    #1;
    chk("alu_prio_FwdRt", {6'd0, FwdRt}, 8'd1);
    ExRdMask = 32'd0;
    #1;
    chk("wb_FwdRt", {6'd0, FwdRt}, 8'd2);
    cyc();

    // Mem-stage hazard: writer to r3 issued, not visible in Ex/Wb.
    idle();
    IdValid = 1'b1; IdRd = 5'd3; IdWb = 1'b1;
    #1;
    chk("mem_issue", {7'd0, IdIssue}, 8'd1);
    cyc();
    idle();
    IdValid = 1'b1; IdRs = 5'd3; IdUseRs = 1'b1;
    #1;
    chk("mem_Stall1", {7'd0, Stall}, 8'd1);
    cyc();
    chk("mem_Stall2", {7'd0, Stall}, 8'd1);
    cyc();
    WbRdMask = 32'd1 << 3;
    #1;
    chk("mem_wb_Stall", {7'd0, Stall}, 8'd0);
    chk("mem_wb_FwdRs", {6'd0, FwdRs}, 8'd2);
    cyc();
    WbRdMask = 32'd0;
    #1;
    chk("mem_clr_Stall", {7'd0, Stall}, 8'd0);
    chk("mem_clr_FwdRs", {6'd0, FwdRs}, 8'd0);
    cyc();

    // Same-cycle set and clear of r7: set wins.
    idle();
    WbRdMask = 32'd1 << 7; IdValid = 1'b1; IdRd = 5'd7; IdWb = 1'b1;
    #1;
    chk("sc_issue", {7'd0, IdIssue}, 8'd1);
    cyc();
    idle();
    IdValid = 1'b1; IdRt = 5'd7; IdUseRt = 1'b1;
    #1;
    chk("sc_Stall", {7'd0, Stall}, 8'd1);
    IdValid = 1'b0; WbRdMask = 32'd1 << 7;
    #1;
    chk("sc_novalid_Stall", {7'd0, Stall}, 8'd0);
    cyc();
    // Writes to r0 never become pending; r0 never hazards or forwards.
    idle();
    IdValid = 1'b1; IdRd = 5'd0; IdWb = 1'b1;
    cyc();
    idle();
    IdValid = 1'b1; IdRs = 5'd7; IdUseRs = 1'b1; IdRt = 5'd0; IdUseRt = 1'b1;
    ExRdMask = 32'd1; ExIsLoad = 1'b1;
    #1;
    chk("r0_Stall", {7'd0, Stall}, 8'd0);
    chk("r0_FwdRt", {6'd0, FwdRt}, 8'd0);
    chk("r0_FwdRs", {6'd0, FwdRs}, 8'd0);
    cyc();

    // Watchdog and total-count saturation on a long load-use stall.
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst2_StallCnt", StallCnt, 8'd0);
    setStall9();
    for (int i = 1; i <= 300; i++) begin
      cyc();
      if (i == 15) chk("wd_15", {7'd0, Watchdog}, 8'd0);
      if (i == 16) begin
        chk("wd_16", {7'd0, Watchdog}, 8'd1);
        chk("cnt_16", StallCnt, 8'd16);
      end
      if (i == 254) chk("cnt_254", StallCnt, 8'd254);
      if (i == 300) chk("cnt_sat", StallCnt, 8'd255);
    end
    // Reset in the middle of a stall clears everything; Stall stays combinational.
    rst_n = 1'b0;
    cyc();
    chk("midrst_StallCnt", StallCnt, 8'd0);
    chk("midrst_Watchdog", {7'd0, Watchdog}, 8'd0);
    chk("midrst_Stall", {7'd0, Stall}, 8'd1);
    rst_n = 1'b1;
    idle();
    cyc();
    setStall9();
    cyc();
    cyc();
    chk("restart_StallCnt", StallCnt, 8'd2);
    idle();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
